id_ex_operand_stage: RTL

- ID/EX pipeline register that captures decoded operands, resolves EX/MEM and MEM/WB forwarding, and presents stable 64-bit A/B operands plus the op select to the execute-stage logic units (AND/OR/XOR/XNOR/ADD).
- A 2-entry skid buffer decouples stalls: in_ready is a registered signal, and a stall never drops an accepted instruction.

---
 rtl/id_ex_operand_stage.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: resolves EX/MEM and MEM/WB forwarding when an
// instruction is accepted and holds the result in a main entry (drives out_*)
// backed by one skid entry, so a downstream stall never drops an instruction
// that has already been accepted.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high (in_valid&in_ready upstream, out_valid&out_ready downstream).
// valid never depends combinationally on ready, and once out_valid is high the
// out_* fields stay bit-stable until the entry is consumed or flushed.
module id_ex_operand_stage #(
   parameter int DATA_W = 64,
   parameter int REG_AW = 5,
   parameter int OP_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   // decode side
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [REG_AW-1:0] in_rs1,
   input  logic [REG_AW-1:0] in_rs2,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [OP_W-1:0]   in_op,
   input  logic              in_wb_en,
   input  logic              flush,
   // forwarding sources
   input  logic              exmem_wb_en,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [DATA_W-1:0] exmem_data,
   input  logic              memwb_wb_en,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [DATA_W-1:0] memwb_data,
   // execute side
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [OP_W-1:0]   out_op,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_wb_en,
   // debug view of the occupancy FSM, {out_valid, skid_valid}
   output logic [1:0]        state
);

   // Occupancy encoded as {out_valid, skid_valid}; 2'b01 is unreachable.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      FULL  = 2'b11
   } state_t;

   state_t cur_state;

   // skid entry storage
   logic [DATA_W-1:0] skid_a;
   logic [DATA_W-1:0] skid_b;
   logic [OP_W-1:0]   skid_op;
   logic [REG_AW-1:0] skid_rd;
   logic              skid_wb_en;

   // forwarded operands for the instruction currently offered by decode
   logic [DATA_W-1:0] fwd_a;
   logic [DATA_W-1:0] fwd_b;

   logic accept;
   logic consume;

   assign out_valid = cur_state[1];
   assign state     = cur_state;
   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready;

   // Operand A forwarding: EX/MEM beats MEM/WB, and x0 never forwards.
   always_comb begin
      fwd_a = in_a;
      if (exmem_wb_en && (exmem_rd == in_rs1) && (in_rs1 != '0)) begin
         fwd_a = exmem_data;
      end else if (memwb_wb_en && (memwb_rd == in_rs1) && (in_rs1 != '0)) begin
         fwd_a = memwb_data;
      end
   end

   // Operand B forwarding: same priority rules as operand A.
   always_comb begin
      fwd_b = in_b;
      if (exmem_wb_en && (exmem_rd == in_rs2) && (in_rs2 != '0)) begin
         fwd_b = exmem_data;
      end else if (memwb_wb_en && (memwb_rd == in_rs2) && (in_rs2 != '0)) begin
         fwd_b = memwb_data;
      end
   end

   // Occupancy FSM with registered outputs: main entry, skid entry and in_ready.
   // in_ready is kept equal to !skid_valid of the next state, so it is a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state  <= EMPTY;
         in_ready   <= 1'b1;
         out_a      <= '0;
         out_b      <= '0;
         out_op     <= '0;
         out_rd     <= '0;
         out_wb_en  <= 1'b0;
         skid_a     <= '0;
         skid_b     <= '0;
         skid_op    <= '0;
         skid_rd    <= '0;
         skid_wb_en <= 1'b0;
      end else if (flush) begin
         // Squash everything, including an instruction accepted this cycle.
         // Data fields may keep stale values; only the write enable is cleared.
         cur_state <= EMPTY;
         in_ready  <= 1'b1;
         out_wb_en <= 1'b0;
      end else begin
         case (cur_state)
            EMPTY: begin
               if (accept) begin
                  out_a     <= fwd_a;
                  out_b     <= fwd_b;
                  out_op    <= in_op;
                  out_rd    <= in_rd;
                  out_wb_en <= in_wb_en;
                  cur_state <= ONE;
               end
            end
            ONE: begin
               if (accept && consume) begin
                  // streaming: replace the consumed main entry directly
                  out_a     <= fwd_a;
                  out_b     <= fwd_b;
                  out_op    <= in_op;
                  out_rd    <= in_rd;
                  out_wb_en <= in_wb_en;
               end else if (accept) begin
                  // main is stalled: park the new instruction in the skid entry
                  skid_a     <= fwd_a;
                  skid_b     <= fwd_b;
                  skid_op    <= in_op;
                  skid_rd    <= in_rd;
                  skid_wb_en <= in_wb_en;
                  cur_state  <= FULL;
                  in_ready   <= 1'b0;
               end else if (consume) begin
                  out_wb_en <= 1'b0;
                  cur_state <= EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only a consume can move the state
               if (consume) begin
                  out_a     <= skid_a;
                  out_b     <= skid_b;
                  out_op    <= skid_op;
                  out_rd    <= skid_rd;
                  out_wb_en <= skid_wb_en;
                  cur_state <= ONE;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               cur_state <= EMPTY;
               in_ready  <= 1'b1;
               out_wb_en <= 1'b0;
            end
         endcase
      end
   end

endmodule
